// File: rtl/alu_pkg.sv
// Shared constants, instruction layout and decode helpers for the ALU issue stage.
// The ALU_ISSUE_FORWARD_EN macro (consumed by alu_issue) enables the writeback bypass.
package alu_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int OPW  = 5;
  localparam int RW   = 5;
  localparam int IMMW = 11;

  localparam logic [OPW-1:0] OP_NOP = 5'b11111;

  localparam int OP_LSB   = 27;
  localparam int RD_LSB   = 22;
  localparam int RS1_LSB  = 17;
  localparam int RS2_LSB  = 12;
  localparam int UIMM_BIT = 11;
  localparam int IMM_LSB  = 0;

  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic            use_imm;
    logic [IMMW-1:0] imm;
  } instr_t;

  function automatic instr_t decode(input logic [31:0] w);
    instr_t d;
    d.opcode  = w[OP_LSB  +: OPW];
    d.rd      = w[RD_LSB  +: RW];
    d.rs1     = w[RS1_LSB +: RW];
    d.rs2     = w[RS2_LSB +: RW];
    d.use_imm = w[UIMM_BIT];
    d.imm     = w[IMM_LSB +: IMMW];
    return d;
  endfunction

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMMW-1:0] imm);
    return {{(XLEN-IMMW){imm[IMMW-1]}}, imm};
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// 32-entry register file: two combinational read ports, one clocked write port.
// r0 is never written and always reads zero.
module alu_regfile
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   ra0,
  input  logic [RW-1:0]   ra1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1,
  input  logic            we,
  input  logic [RW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);
  logic [NREG-1:0][XLEN-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we && wa != '0) mem_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rdata0 = (ra0 == '0) ? '0 : mem_q[ra0];
  assign rdata1 = (ra1 == '0) ? '0 : mem_q[ra1];
endmodule

// File: rtl/alu_issue.sv
// Operand fetch / issue stage ahead of the ALU: one-entry buffer, busy scoreboard, writeback port.
// Define ALU_ISSUE_FORWARD_EN to bypass same-cycle writeback data into hazard check and operands.
module alu_issue
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [OPW-1:0]  alu_opcode,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            alu_enable,
  output logic [RW-1:0]   alu_rd,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [15:0]     stall_cnt
);
  logic            buf_valid_q, buf_valid_d;
  instr_t          buf_q, buf_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [OPW-1:0]  alu_opcode_q, alu_opcode_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic            alu_enable_q, alu_enable_d;
  logic [RW-1:0]   alu_rd_q, alu_rd_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic [XLEN-1:0] r1, r2, op_a, op_b;
  logic            is_nop, hazard, issue_now, accept;
  logic            fwd1, fwd2, fwdd;

  alu_regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .ra0    (buf_q.rs1),
    .ra1    (buf_q.rs2),
    .rdata0 (r1),
    .rdata1 (r2),
    .we     (wb_en),
    .wa     (wb_rd),
    .wd     (wb_data)
  );

  always_comb begin
    fwd1 = 1'b0;
    fwd2 = 1'b0;
    fwdd = 1'b0;
`ifdef ALU_ISSUE_FORWARD_EN
    fwd1 = wb_en && wb_rd == buf_q.rs1 && buf_q.rs1 != '0;
    fwd2 = wb_en && wb_rd == buf_q.rs2 && buf_q.rs2 != '0;
    fwdd = wb_en && wb_rd == buf_q.rd  && buf_q.rd  != '0;
`endif
    is_nop    = buf_q.opcode == OP_NOP;
    // NOPs bypass the hazard check entirely so they never accumulate stall cycles
    hazard    = buf_valid_q && !is_nop &&
                ((busy_q[buf_q.rs1] && !fwd1) ||
                 (!buf_q.use_imm && busy_q[buf_q.rs2] && !fwd2) ||
                 (busy_q[buf_q.rd] && !fwdd));
    issue_now = buf_valid_q && !hazard && !is_nop;
    in_ready  = !buf_valid_q || issue_now;
    accept    = in_valid && in_ready;
    op_a      = fwd1 ? wb_data : r1;
    op_b      = buf_q.use_imm ? sext_imm(buf_q.imm) : (fwd2 ? wb_data : r2);
  end

  always_comb begin
    buf_d       = accept ? decode(in_instr) : buf_q;
    buf_valid_d = buf_valid_q;
    if (accept)                                buf_valid_d = 1'b1;
    else if (issue_now || (buf_valid_q && is_nop)) buf_valid_d = 1'b0;

    // clear first so a same-edge issue to the same rd leaves the bit set
    busy_d = busy_q;
    if (wb_en && wb_rd != '0)         busy_d[wb_rd]    = 1'b0;
    if (issue_now && buf_q.rd != '0)  busy_d[buf_q.rd] = 1'b1;

    alu_enable_d = issue_now;
    alu_opcode_d = issue_now ? buf_q.opcode : alu_opcode_q;
    alu_rd_d     = issue_now ? buf_q.rd     : alu_rd_q;
    alu_a_d      = issue_now ? op_a         : alu_a_q;
    alu_b_d      = issue_now ? op_b         : alu_b_q;

    stall_cnt_d = stall_cnt_q;
    if (hazard && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q  <= 1'b0;
      buf_q        <= '0;
      busy_q       <= '0;
      alu_enable_q <= 1'b0;
      alu_opcode_q <= '0;
      alu_rd_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      stall_cnt_q  <= '0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      buf_q        <= buf_d;
      busy_q       <= busy_d;
      alu_enable_q <= alu_enable_d;
      alu_opcode_q <= alu_opcode_d;
      alu_rd_q     <= alu_rd_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign alu_enable = alu_enable_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_rd     = alu_rd_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected issues queued at stimulus time, popped on alu_enable.
module tb_alu_issue;
`ifdef ALU_ISSUE_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a, alu_b;
  logic        alu_enable;
  logic [4:0]  alu_rd;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [15:0] stall_cnt;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_enable(alu_enable),
    .alu_rd(alu_rd), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  int          issue_cycs[$];
  int          cyc = 0;
  int          en_count = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;
  logic [31:0] model_r[32];
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && alu_enable) begin
      en_count++;
      issue_cycs.push_back(cyc);
      tot_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL spurious_issue cyc=%0d op=%0d a=%h b=%h rd=%0d, none expected",
                 cyc, alu_opcode, alu_a, alu_b, alu_rd);
      end else begin
        mon_e = exp_q.pop_front();
        if ({alu_opcode, alu_a, alu_b, alu_rd} !== {mon_e.op, mon_e.a, mon_e.b, mon_e.rd})
          $display("FAIL issue_fields got op=%0d a=%h b=%h rd=%0d exp op=%0d a=%h b=%h rd=%0d",
                   alu_opcode, alu_a, alu_b, alu_rd, mon_e.op, mon_e.a, mon_e.b, mon_e.rd);
        else pass_cnt++;
      end
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic ui, input logic [10:0] imm);
    return {op, rd, rs1, rs2, ui, imm};
  endfunction

  function automatic logic [31:0] sx(input logic [10:0] imm);
    return {{21{imm[10]}}, imm};
  endfunction

  task automatic push_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] ins, output int acc);
    acc = -1;
    in_valid = 1'b1;
    in_instr = ins;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    tot_cnt++;
    $display("FAIL send_timeout instr=%h not accepted within 50 cycles", ins);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    wb_en = 1'b1; wb_rd = rd; wb_data = data;
    @(posedge clk); #1;
    wb_en = 1'b0;
    if (rd != 0) model_r[rd] = data;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    wb_en = 1'b0;
    exp_q.delete();
    issue_cycs.delete();
    for (int i = 0; i < 32; i++) model_r[i] = '0;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int acc, en0;
    #1;
    tot_cnt++;
    if ({alu_enable, alu_opcode, alu_a, alu_b, alu_rd, stall_cnt, in_ready} !==
        {1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 16'd0, 1'b1})
      $display("FAIL reset_initial got en=%b op=%0d a=%h b=%h rd=%0d stall=%0d rdy=%b exp zeros rdy=1",
               alu_enable, alu_opcode, alu_a, alu_b, alu_rd, stall_cnt, in_ready);
    else pass_cnt++;
    do_reset();
    wb(5, 32'hDEADBEEF);
    push_exp(5'd1, 32'd0, 32'd4, 5'd6);
    send(mk(5'd1, 5'd6, 5'd0, 5'd0, 1'b1, 11'd4), acc);
    send(mk(5'd2, 5'd7, 5'd6, 5'd0, 1'b1, 11'd0), acc);
    wait_cycles(2);
    tot_cnt++;
    if (exp_q.size() != 0) $display("FAIL reset_pre_issue got pending=%0d exp 0", exp_q.size());
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    tot_cnt++;
    if ({alu_enable, alu_opcode, alu_a, alu_b, alu_rd, stall_cnt, in_ready} !==
        {1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 16'd0, 1'b1})
      $display("FAIL reset_midstream got en=%b op=%0d a=%h b=%h rd=%0d stall=%0d rdy=%b exp zeros rdy=1",
               alu_enable, alu_opcode, alu_a, alu_b, alu_rd, stall_cnt, in_ready);
    else pass_cnt++;
    en0 = en_count;
    do_reset();
    wait_cycles(4);
    tot_cnt++;
    if (en_count != en0) $display("FAIL reset_buffer_drop got pulses=%0d exp 0", en_count - en0);
    else pass_cnt++;
    push_exp(5'd3, 32'd0, 32'd0, 5'd8);
    send(mk(5'd3, 5'd8, 5'd5, 5'd6, 1'b0, 11'd0), acc);
    wait_cycles(2);
    tot_cnt++;
    if (issue_cycs.size() != 1 || issue_cycs[0] != acc + 1)
      $display("FAIL reset_busy_cleared got issues=%0d exp one issue at cyc %0d", issue_cycs.size(), acc + 1);
    else pass_cnt++;
  endtask

  task automatic test_imm();
    int acc, en0;
    do_reset();
    en0 = en_count;
    push_exp(5'd0, 32'd0, sx(11'h7FF), 5'd3);
    send(mk(5'd0, 5'd3, 5'd0, 5'd0, 1'b1, 11'h7FF), acc);
    wait_cycles(3);
    tot_cnt++;
    if (en_count - en0 != 1) $display("FAIL imm_pulse_count got %0d exp 1", en_count - en0);
    else pass_cnt++;
    tot_cnt++;
    if (issue_cycs.size() != 1 || issue_cycs[0] != acc + 1)
      $display("FAIL imm_latency got issues=%0d exp issue at cyc %0d", issue_cycs.size(), acc + 1);
    else pass_cnt++;
  endtask

  task automatic test_raw_stall();
    int acc, wbedge;
    do_reset();
    push_exp(5'd1, 32'd0, 32'd5, 5'd3);
    send(mk(5'd1, 5'd3, 5'd0, 5'd0, 1'b1, 11'd5), acc);
    push_exp(5'd2, 32'h0F0F0F0F, 32'd1, 5'd4);
    send(mk(5'd2, 5'd4, 5'd3, 5'd0, 1'b1, 11'd1), acc);
    repeat (3) @(posedge clk);
    #1;
    wb(3, 32'h0F0F0F0F);
    wbedge = acc + 4;
    wait_cycles(3);
    tot_cnt++;
    if (issue_cycs.size() != 2 || issue_cycs[1] != wbedge + 1 - FWD)
      $display("FAIL raw_issue_edge got issues=%0d exp second issue at cyc %0d", issue_cycs.size(), wbedge + 1 - FWD);
    else pass_cnt++;
    tot_cnt++;
    if (stall_cnt !== 16'(4 - FWD)) $display("FAIL raw_stall_cnt got %0d exp %0d", stall_cnt, 4 - FWD);
    else pass_cnt++;
    tot_cnt++;
    if (exp_q.size() != 0) $display("FAIL raw_pending got %0d exp 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int en0;
    do_reset();
    wb(1, 32'd11);
    wb(2, 32'd22);
    en0 = en_count;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = mk(5'(i + 4), 5'(i + 5), 5'd1, 5'd2, 1'b0, 11'd0);
      push_exp(5'(i + 4), model_r[1], model_r[2], 5'(i + 5));
      @(negedge clk);
      tot_cnt++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d got %b exp 1", i, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_cycles(3);
    tot_cnt++;
    if (en_count - en0 != 4) $display("FAIL b2b_pulse_count got %0d exp 4", en_count - en0);
    else pass_cnt++;
    tot_cnt++;
    if (issue_cycs.size() != 4 || issue_cycs[3] - issue_cycs[0] != 3)
      $display("FAIL b2b_consecutive got issues=%0d exp 4 in consecutive cycles", issue_cycs.size());
    else pass_cnt++;
  endtask

  task automatic test_nop_r0();
    int acc, en0;
    do_reset();
    en0 = en_count;
    send(mk(5'b11111, 5'd9, 5'd0, 5'd0, 1'b1, 11'd0), acc);
    wait_cycles(3);
    tot_cnt++;
    if (en_count != en0 || stall_cnt !== 16'd0)
      $display("FAIL nop_no_pulse got pulses=%0d stall=%0d exp 0 0", en_count - en0, stall_cnt);
    else pass_cnt++;
    push_exp(5'd1, 32'd0, 32'd2, 5'd10);
    send(mk(5'd1, 5'd10, 5'd9, 5'd0, 1'b1, 11'd2), acc);
    wait_cycles(2);
    tot_cnt++;
    if (issue_cycs.size() != 1 || issue_cycs[0] != acc + 1)
      $display("FAIL nop_no_busy got issues=%0d exp issue at cyc %0d", issue_cycs.size(), acc + 1);
    else pass_cnt++;
    wb(0, 32'h70F0F0F0);
    push_exp(5'd2, 32'd0, 32'd0, 5'd0);
    send(mk(5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 11'd0), acc);
    push_exp(5'd3, 32'd0, 32'd0, 5'd0);
    send(mk(5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 11'd0), acc);
    wait_cycles(2);
    tot_cnt++;
    if (issue_cycs.size() != 3 || issue_cycs[2] != acc + 1)
      $display("FAIL r0_no_busy got issues=%0d exp third issue at cyc %0d", issue_cycs.size(), acc + 1);
    else pass_cnt++;
  endtask

  task automatic test_same_edge();
    int acc, en0;
    do_reset();
    push_exp(5'd1, 32'd0, 32'd1, 5'd7);
    send(mk(5'd1, 5'd7, 5'd0, 5'd0, 1'b1, 11'd1), acc);
    wb(7, 32'h11111111);
    push_exp(5'd2, 32'h22222222, 32'd0, 5'd8);
    send(mk(5'd2, 5'd8, 5'd7, 5'd0, 1'b1, 11'd0), acc);
    en0 = en_count;
    wait_cycles(4);
    tot_cnt++;
    if (en_count != en0) $display("FAIL same_edge_busy_kept got pulses=%0d exp 0", en_count - en0);
    else pass_cnt++;
    tot_cnt++;
    if (stall_cnt !== 16'd4) $display("FAIL same_edge_stall got %0d exp 4", stall_cnt);
    else pass_cnt++;
    wb(7, 32'h22222222);
    wait_cycles(3);
    tot_cnt++;
    if (en_count - en0 != 1 || exp_q.size() != 0)
      $display("FAIL same_edge_release got pulses=%0d pending=%0d exp 1 0", en_count - en0, exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_r[i] = '0;
    test_reset();
    test_imm();
    test_raw_stall();
    test_back_to_back();
    test_nop_r0();
    test_same_edge();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end
endmodule
